// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard/sequencing controller:
// ID/MEM stage status in one direction, register enables, flushes and status in the other.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 6,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_regwrite;
  logic [REG_AW-1:0] id_rd;
  logic              mem_redirect;
  logic              mem_jumpm;
  logic              mem_data_valid;

  logic              pc_we;
  logic [1:0]        pc_sel;
  logic              if_id_we;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              ex_m_flush;
  logic [1:0]        state;
  logic              memj_err;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_regwrite, id_rd,
           mem_redirect, mem_jumpm, mem_data_valid,
    input  pc_we, pc_sel, if_id_we, if_id_flush, id_ex_flush, ex_m_flush,
           state, memj_err, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_regwrite, id_rd,
           mem_redirect, mem_jumpm, mem_data_valid,
    output pc_we, pc_sel, if_id_we, if_id_flush, id_ex_flush, ex_m_flush,
           state, memj_err, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: RAW stall via a shadow writer scoreboard,
// MEM-stage redirect flushes, and a bounded wait for memory-indirect jump targets.
module pipeline_hazard_ctrl #(
  parameter int REG_AW       = 6,
  parameter int MEMJ_TIMEOUT = 16,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEMJ_WAIT = 2'd1,
    ERR_ABORT = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
  } sh_t;

  localparam int WCW = $clog2(MEMJ_TIMEOUT) + 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEMJ_TIMEOUT - 1);

  state_t           state_q;
  sh_t              sh_ex;
  sh_t              sh_mem;
  sh_t              sh_wb;
  logic [WCW-1:0]   wait_cnt;
  logic             err_q;
  logic [CNT_W-1:0] stall_q;

  logic rs_hit;
  logic rt_hit;
  logic hz;

  // No forwarding: any in-flight writer of a source register blocks ID.
  assign rs_hit = (sh_ex.valid  && sh_ex.rd  == bus.id_rs) ||
                  (sh_mem.valid && sh_mem.rd == bus.id_rs) ||
                  (sh_wb.valid  && sh_wb.rd  == bus.id_rs);
  assign rt_hit = (sh_ex.valid  && sh_ex.rd  == bus.id_rt) ||
                  (sh_mem.valid && sh_mem.rd == bus.id_rt) ||
                  (sh_wb.valid  && sh_wb.rd  == bus.id_rt);
  assign hz     = (bus.id_use_rs && rs_hit) || (bus.id_use_rt && rt_hit);

  always_comb begin
    bus.pc_we       = 1'b0;
    bus.pc_sel      = 2'd0;
    bus.if_id_we    = 1'b0;
    bus.if_id_flush = 1'b0;
    bus.id_ex_flush = 1'b0;
    bus.ex_m_flush  = 1'b0;
    if (rst) begin
      bus.if_id_flush = 1'b1;
      bus.id_ex_flush = 1'b1;
      bus.ex_m_flush  = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.mem_jumpm) begin
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
            bus.ex_m_flush  = 1'b1;
          end else if (bus.mem_redirect) begin
            // Redirect wins over a hazard: the stalled instruction is being killed anyway.
            bus.pc_we       = 1'b1;
            bus.pc_sel      = 2'd1;
            bus.if_id_we    = 1'b1;
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
            bus.ex_m_flush  = 1'b1;
          end else if (hz) begin
            bus.id_ex_flush = 1'b1;
          end else begin
            bus.pc_we    = 1'b1;
            bus.if_id_we = 1'b1;
          end
        end
        MEMJ_WAIT: begin
          bus.if_id_flush = 1'b1;
          bus.id_ex_flush = 1'b1;
          if (bus.mem_data_valid) begin
            bus.pc_we  = 1'b1;
            bus.pc_sel = 2'd2;
          end
        end
        ERR_ABORT: begin
          bus.pc_we       = 1'b1;
          bus.if_id_flush = 1'b1;
        end
        default: begin
          bus.pc_we = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      sh_ex    <= '0;
      sh_mem   <= '0;
      sh_wb    <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
      stall_q  <= '0;
    end else begin
      sh_wb  <= sh_mem;
      sh_mem <= bus.ex_m_flush  ? '0 : sh_ex;
      sh_ex  <= bus.id_ex_flush ? '0 : sh_t'{bus.id_regwrite, bus.id_rd};

      if (!bus.pc_we && stall_q != '1) begin
        stall_q <= stall_q + 1'b1;
      end

      unique case (state_q)
        RUN: begin
          if (bus.mem_jumpm) begin
            wait_cnt <= '0;
            state_q  <= MEMJ_WAIT;
          end
        end
        MEMJ_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (bus.mem_data_valid) begin
            state_q <= RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            err_q   <= 1'b1;
            state_q <= ERR_ABORT;
          end
        end
        ERR_ABORT: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign bus.state     = state_q;
  assign bus.memj_err  = err_q;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected decode per cycle is queued
// when inputs are driven and compared on the following falling edge.
module tb_pipeline_hazard_ctrl;

  localparam int REG_AW = 6;
  localparam int CNT_W  = 16;

  // {chk_we, pc_we, pc_sel, if_id_we, if_id_flush, id_ex_flush, ex_m_flush, state, memj_err}
  typedef logic [10:0] exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  exp_t  exp_q[$];
  string tag_q[$];

  pipeline_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(
    .REG_AW(REG_AW),
    .MEMJ_TIMEOUT(16),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic chk, input logic pc_we, input logic [1:0] sel,
                              input logic we, input logic f1, input logic f2, input logic f3,
                              input logic [1:0] st, input logic err);
    return {chk, pc_we, sel, we, f1, f2, f3, st, err};
  endfunction

  function automatic exp_t expN(input logic err);
    return mk(1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, err);
  endfunction
  function automatic exp_t expH();
    return mk(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
  endfunction
  function automatic exp_t expR();
    return mk(1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
  endfunction
  function automatic exp_t expJ(input logic err);
    return mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, err);
  endfunction
  function automatic exp_t expW(input logic err);
    return mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, err);
  endfunction
  function automatic exp_t expWV();
    return mk(1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
  endfunction
  function automatic exp_t expE();
    return mk(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1);
  endfunction
  function automatic exp_t expRst(input logic [1:0] st, input logic err);
    return mk(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, st, err);
  endfunction

  task automatic setIdle();
    rst                = 1'b0;
    bus.id_rs          = '0;
    bus.id_rt          = '0;
    bus.id_use_rs      = 1'b0;
    bus.id_use_rt      = 1'b0;
    bus.id_regwrite    = 1'b0;
    bus.id_rd          = '0;
    bus.mem_redirect   = 1'b0;
    bus.mem_jumpm      = 1'b0;
    bus.mem_data_valid = 1'b0;
  endtask

  task automatic applyStimulus(input string tag, input exp_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
  endtask

  task automatic checkOutput(input int exp_stall);
    exp_t  e;
    exp_t  o;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {e[10], bus.pc_we, bus.pc_sel, (e[10] ? bus.if_id_we : e[6]),
         bus.if_id_flush, bus.id_ex_flush, bus.ex_m_flush, bus.state, bus.memj_err};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", t, o, e);
    end
    if (exp_stall >= 0) begin
      vectors++;
      assert (bus.stall_cnt === CNT_W'(exp_stall)) else begin
        miscompares++;
        $error("[TB] FAIL %s stall_cnt: observed %0d expected %0d", t, bus.stall_cnt, exp_stall);
      end
    end
  endtask

  task automatic step(input string tag, input exp_t e, input int exp_stall);
    applyStimulus(tag, e);
    checkOutput(exp_stall);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    setIdle();
    rst = 1'b1;
    @(posedge clk);
    #1;

    step("reset0", expRst(2'd0, 1'b0), -1);
    step("reset1", expRst(2'd0, 1'b0), -1);
    rst = 1'b0;
    step("idle_after_reset", expN(1'b0), 0);

    // RAW on rs: writer r5 then a reader, three stall cycles until WB drains
    bus.id_regwrite = 1'b1; bus.id_rd = 6'd5;
    step("writer_r5", expN(1'b0), -1);
    setIdle(); bus.id_rs = 6'd5; bus.id_use_rs = 1'b1;
    for (int i = 0; i < 3; i++) step("raw_rs_stall", expH(), -1);
    step("raw_rs_resume", expN(1'b0), 3);

    // no false hazards
    setIdle(); bus.id_regwrite = 1'b1; bus.id_rd = 6'd9;
    step("writer_r9", expN(1'b0), -1);
    setIdle(); bus.id_rs = 6'd9; bus.id_rt = 6'd2; bus.id_use_rt = 1'b1;
    step("rs_unused", expN(1'b0), -1);
    setIdle(); bus.id_rd = 6'd12;
    step("nonwriter_r12", expN(1'b0), -1);
    setIdle(); bus.id_rt = 6'd12; bus.id_use_rt = 1'b1;
    step("rt_after_nonwriter", expN(1'b0), 3);

    // RAW on rt
    setIdle(); bus.id_regwrite = 1'b1; bus.id_rd = 6'd20;
    step("writer_r20", expN(1'b0), -1);
    setIdle(); bus.id_rt = 6'd20; bus.id_use_rt = 1'b1;
    for (int i = 0; i < 3; i++) step("raw_rt_stall", expH(), -1);
    step("raw_rt_resume", expN(1'b0), 6);

    // redirect overrides a live hazard and invalidates sh_ex/sh_mem
    setIdle(); bus.id_regwrite = 1'b1; bus.id_rd = 6'd7;
    step("writer_r7", expN(1'b0), -1);
    setIdle(); bus.id_regwrite = 1'b1; bus.id_rd = 6'd8;
    step("writer_r8", expN(1'b0), -1);
    setIdle(); bus.id_rs = 6'd8; bus.id_use_rs = 1'b1; bus.id_regwrite = 1'b1;
    bus.id_rd = 6'd8; bus.mem_redirect = 1'b1;
    step("redirect_over_hz", expR(), -1);
    setIdle(); bus.id_rs = 6'd8; bus.id_use_rs = 1'b1;
    step("after_redirect_no_hz", expN(1'b0), 6);

    // JumpM with target after four wait cycles; redirect/jumpm ignored while waiting
    setIdle(); bus.mem_jumpm = 1'b1; bus.mem_redirect = 1'b1;
    step("jumpm_enter", expJ(1'b0), -1);
    setIdle();
    step("memj_wait0", expW(1'b0), -1);
    bus.mem_jumpm = 1'b1; bus.mem_redirect = 1'b1;
    step("memj_wait_ignore", expW(1'b0), -1);
    setIdle();
    step("memj_wait2", expW(1'b0), -1);
    step("memj_wait3", expW(1'b0), -1);
    bus.mem_data_valid = 1'b1;
    step("memj_target", expWV(), -1);
    setIdle();
    step("memj_back_run", expN(1'b0), 11);

    // timeout: sixteen waits, abort cycle, sticky error
    bus.mem_jumpm = 1'b1;
    step("jumpm_timeout_enter", expJ(1'b0), -1);
    setIdle();
    for (int i = 0; i < 16; i++) step("memj_wait_to", expW(1'b0), -1);
    step("err_abort", expE(), -1);
    step("run_err_sticky0", expN(1'b1), 28);
    step("run_err_sticky1", expN(1'b1), -1);

    // reset in the middle of a wait clears the error and returns to RUN
    bus.mem_jumpm = 1'b1;
    step("jumpm_before_rst", expJ(1'b1), -1);
    setIdle();
    step("memj_wait_pre_rst0", expW(1'b1), -1);
    step("memj_wait_pre_rst1", expW(1'b1), -1);
    rst = 1'b1;
    step("rst_mid_wait", expRst(2'd1, 1'b1), -1);
    setIdle();
    step("run_after_rst", expN(1'b0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
